// File: rtl/demux_rr.sv
// demux_rr: 1-to-NUM_CH demultiplexer with a one-entry registered slot per
// channel and valid/ready handshakes on both sides.
//
// MODE=0 distributes beats round-robin in strict order (ptr selects the target
// and only advances when a beat is accepted). MODE=1 takes the target from
// sel_in; a select at or above NUM_CH is accepted and dropped, and err pulses
// for one cycle afterwards.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   data_in    upstream data beat
//   valid_in   upstream beat valid
//   sel_in     target channel (MODE=1 only)
//   ready_in   beat can be accepted this cycle (combinational)
//   data_out   channel k at [k*DATA_W +: DATA_W]
//   valid_out  slot k holds a beat
//   ready_out  consumer k takes its beat this cycle
//   ptr        current round-robin target (held at 0 in MODE=1)
//   err        one-cycle pulse after an illegal-select beat was dropped

module demux_rr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned MODE   = 0,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic [SEL_W-1:0]         sel_in,
  output logic                     ready_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  input  logic [NUM_CH-1:0]        ready_out,
  output logic [SEL_W-1:0]         ptr,
  output logic                     err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  target_c;
  logic              illegal_c;
  logic              free_c;
  logic              accept_c;
  logic              load_c;
  logic [NUM_CH-1:0] slot_free_c;
  logic [NUM_CH-1:0] load_sel_c;

  // Target selection, handshake and per-slot load decode.
  always_comb begin
    target_c    = (MODE == 1) ? sel_in : ptr;
    illegal_c   = (MODE == 1) && (32'(sel_in) >= 32'(NUM_CH));
    // A slot can take a new beat if empty or being drained this same cycle.
    slot_free_c = ~valid_out | ready_out;
    free_c      = 1'b0;
    load_sel_c  = '0;
    // Loop decode keeps an out-of-range select from indexing past the slots.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (target_c == SEL_W'(k)) begin
        free_c = slot_free_c[k];
      end
    end
    ready_in = !reset && (illegal_c || free_c);
    accept_c = valid_in && ready_in;
    load_c   = accept_c && !illegal_c;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      load_sel_c[k] = load_c && (target_c == SEL_W'(k));
    end
  end

  // Slot registers, round-robin pointer and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= '0;
      ptr       <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept_c && illegal_c;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (load_sel_c[k]) begin
          // Load wins over a same-cycle drain: no bubble.
          data_out[k*DATA_W +: DATA_W] <= data_in;
          valid_out[k]                 <= 1'b1;
        end else if (ready_out[k]) begin
          // Data is left in place after a drain.
          valid_out[k] <= 1'b0;
        end
      end
      if ((MODE == 0) && load_c) begin
        ptr <= (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_rr.sv
// tb_demux_rr: directed self-checking bench for demux_rr.
// Three instances cover round-robin (4 x 8b), explicit select with an
// illegal code (3 x 8b) and a 2-channel 16-bit corner. Expected beats are
// queued when driven and popped when the DUT presents them.

module tb_demux_rr;

  typedef struct {
    int unsigned inst;
    int unsigned ch;
    logic [15:0] data;
  } sb_t;

  logic clk;
  int unsigned total;
  int unsigned bad;
  sb_t sb_q[$];

  // Instance 0: MODE=0, NUM_CH=4, DATA_W=8
  logic        rst0;
  logic [7:0]  d0;
  logic        v0;
  logic [1:0]  s0;
  logic        ri0;
  logic [31:0] do0;
  logic [3:0]  vo0;
  logic [3:0]  ro0;
  logic [1:0]  p0;
  logic        e0;

  // Instance 1: MODE=1, NUM_CH=3, DATA_W=8
  logic        rst1;
  logic [7:0]  d1;
  logic        v1;
  logic [1:0]  s1;
  logic        ri1;
  logic [23:0] do1;
  logic [2:0]  vo1;
  logic [2:0]  ro1;
  logic [1:0]  p1;
  logic        e1;

  // Instance 2: MODE=0, NUM_CH=2, DATA_W=16
  logic        rst2;
  logic [15:0] d2;
  logic        v2;
  logic [0:0]  s2;
  logic        ri2;
  logic [31:0] do2;
  logic [1:0]  vo2;
  logic [1:0]  ro2;
  logic [0:0]  p2;
  logic        e2;

  demux_rr #(.DATA_W(8), .NUM_CH(4), .MODE(0)) u0 (
    .clk(clk), .reset(rst0), .data_in(d0), .valid_in(v0), .sel_in(s0),
    .ready_in(ri0), .data_out(do0), .valid_out(vo0), .ready_out(ro0),
    .ptr(p0), .err(e0)
  );

  demux_rr #(.DATA_W(8), .NUM_CH(3), .MODE(1)) u1 (
    .clk(clk), .reset(rst1), .data_in(d1), .valid_in(v1), .sel_in(s1),
    .ready_in(ri1), .data_out(do1), .valid_out(vo1), .ready_out(ro1),
    .ptr(p1), .err(e1)
  );

  demux_rr #(.DATA_W(16), .NUM_CH(2), .MODE(0)) u2 (
    .clk(clk), .reset(rst2), .data_in(d2), .valid_in(v2), .sel_in(s2),
    .ready_in(ri2), .data_out(do2), .valid_out(vo2), .ready_out(ro2),
    .ptr(p2), .err(e2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected beat and compare against its instance's slots.
  task automatic sb_check();
    sb_t e;
    logic [3:0] oh4;
    logic [1:0] oh2;
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.inst == 0) begin
        oh4 = 4'b0001 << e.ch;
        chk("sb_valid0", 64'(vo0), 64'(oh4));
        chk("sb_data0", 64'(do0[e.ch*8 +: 8]), 64'(e.data[7:0]));
      end else begin
        oh2 = 2'b01 << e.ch;
        chk("sb_valid2", 64'(vo2), 64'(oh2));
        chk("sb_data2", 64'(do2[e.ch*16 +: 16]), 64'(e.data));
      end
    end
  endtask

  // Single beat into instance 0 that must be accepted immediately.
  task automatic send0(input logic [7:0] data);
    d0 = data;
    v0 = 1'b1;
    #1;
    chk("fill_ready0", 64'(ri0), 64'(1));
    tick();
    v0 = 1'b0;
  endtask

  initial begin
    int unsigned mptr;
    logic [7:0] b;
    total = 0;
    bad   = 0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    d0 = '0; v0 = 1'b0; s0 = '0; ro0 = '1;
    d1 = '0; v1 = 1'b0; s1 = '0; ro1 = '0;
    d2 = '0; v2 = 1'b0; s2 = '0; ro2 = '1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_in", 64'(ri0), 64'(0));
    chk("rst_valid_out", 64'(vo0), 64'(0));
    chk("rst_data_out", 64'(do0), 64'(0));
    chk("rst_ptr", 64'(p0), 64'(0));
    chk("rst_err", 64'(e0), 64'(0));
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    chk("idle_ready_in", 64'(ri0), 64'(1));

    // Round-robin sweep 0x10..0x17
    mptr = 0;
    for (int i = 0; i < 8; i++) begin
      b  = 8'h10 + 8'(i);
      d0 = b;
      v0 = 1'b1;
      #1;
      chk("rr_ready_in", 64'(ri0), 64'(1));
      chk("rr_ptr", 64'(p0), 64'(mptr));
      sb_q.push_back('{inst: 0, ch: mptr, data: 16'(b)});
      tick();
      sb_check();
      mptr = (mptr == 3) ? 0 : mptr + 1;
    end
    v0 = 1'b0;
    chk("rr_ptr_wrap", 64'(p0), 64'(0));

    // Backpressure stall: ch1 holds 0xAA, 0x55 waits at ptr=1
    ro0 = 4'b1101;
    send0(8'h01);
    send0(8'hAA);
    send0(8'h02);
    send0(8'h03);
    send0(8'h04);
    chk("bp_ptr_pre", 64'(p0), 64'(1));
    d0 = 8'h55;
    v0 = 1'b1;
    #1;
    chk("bp_ready_low", 64'(ri0), 64'(0));
    tick();
    tick();
    chk("bp_ptr_hold", 64'(p0), 64'(1));
    chk("bp_data_hold", 64'(do0[15:8]), 64'(8'hAA));
    chk("bp_valid_hold", 64'(vo0[1]), 64'(1));
    ro0 = 4'b1111;
    #1;
    chk("bp_ready_rise", 64'(ri0), 64'(1));
    tick();
    v0 = 1'b0;
    chk("bp_data_swap", 64'(do0[15:8]), 64'(8'h55));
    chk("bp_valid_stay", 64'(vo0), 64'(4'b0010));
    chk("bp_ptr_adv", 64'(p0), 64'(2));
    tick();
    chk("bp_drained", 64'(vo0), 64'(0));

    // Independent drain: fill ch2,3,0,1 then release ch1/ch3
    ro0 = 4'b0000;
    send0(8'hC0);
    send0(8'hC1);
    send0(8'hC2);
    send0(8'hC3);
    chk("dr_full", 64'(vo0), 64'(4'b1111));
    d0 = 8'hEE;
    v0 = 1'b1;
    #1;
    chk("dr_full_ready", 64'(ri0), 64'(0));
    v0 = 1'b0;
    ro0 = 4'b1010;
    tick();
    chk("dr_valid", 64'(vo0), 64'(4'b0101));
    chk("dr_data1", 64'(do0[15:8]), 64'(8'hC3));
    chk("dr_data3", 64'(do0[31:24]), 64'(8'hC1));

    // Reset mid-operation with valid_in high
    ro0 = 4'b0000;
    chk("mr_ptr_pre", 64'(p0), 64'(2));
    d0 = 8'h77;
    v0 = 1'b1;
    rst0 = 1'b1;
    #1;
    chk("mr_ready_in", 64'(ri0), 64'(0));
    tick();
    rst0 = 1'b0;
    v0 = 1'b0;
    chk("mr_valid", 64'(vo0), 64'(0));
    chk("mr_data", 64'(do0), 64'(0));
    chk("mr_ptr", 64'(p0), 64'(0));
    chk("mr_err", 64'(e0), 64'(0));

    // Explicit select, then illegal select on a 3-channel instance
    s1 = 2'd2;
    d1 = 8'h3C;
    v1 = 1'b1;
    #1;
    chk("sel_ready", 64'(ri1), 64'(1));
    tick();
    chk("sel_valid", 64'(vo1), 64'(3'b100));
    chk("sel_data", 64'(do1[23:16]), 64'(8'h3C));
    chk("sel_ptr", 64'(p1), 64'(0));
    d1 = 8'h11;
    #1;
    chk("sel_busy_ready", 64'(ri1), 64'(0));
    s1 = 2'd3;
    d1 = 8'h99;
    #1;
    chk("ill_ready", 64'(ri1), 64'(1));
    tick();
    v1 = 1'b0;
    chk("ill_err", 64'(e1), 64'(1));
    chk("ill_valid", 64'(vo1), 64'(3'b100));
    chk("ill_data", 64'(do1), 64'(24'h3C0000));
    tick();
    chk("ill_err_pulse", 64'(e1), 64'(0));

    // Parameter corner: 2 channels, 16-bit data
    mptr = 0;
    for (int i = 0; i < 2; i++) begin
      d2 = (i == 0) ? 16'hBEEF : 16'hCAFE;
      v2 = 1'b1;
      #1;
      chk("pc_ready", 64'(ri2), 64'(1));
      sb_q.push_back('{inst: 2, ch: mptr, data: d2});
      tick();
      sb_check();
      mptr = (mptr == 1) ? 0 : mptr + 1;
    end
    v2 = 1'b0;
    chk("pc_ptr_wrap", 64'(p2), 64'(0));
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
